rc4_stream: RTL
===============

Name: rc4_stream

Overview:
- Parametrised RC4 cipher engine. Runs the key schedule (S-box init plus KSA) and then the PRGA, XORing one keystream byte per accepted input byte.
- Sits between a byte-stream producer and consumer, with valid/ready on both sides.
- Extends the fixed 4-byte-key core with a configurable key length, RC4-drop[N] discard, rekey-on-the-fly, error reporting and a backpressured stream interface.

Parameters:
- KEY_MAX_BYTES, 16, maximum key length in bytes (1..256).
- DROP_N, 0, number of keystream bytes generated and discarded after KSA, before streaming starts.
- KLW, $clog2(KEY_MAX_BYTES+1), width of key_len (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to (re)key; latches key and key_len.
- key  in  8*KEY_MAX_BYTES  key bytes; byte n = key[8n+7:8n].
- key_len  in  KLW  number of valid key bytes.
- in_valid  in  1  plaintext byte valid.
- in_ready  out  1  engine accepts the in_data byte.
- in_data  in  8  plaintext/ciphertext byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  8  in_data XOR keystream byte.
- busy  out  1  high in INIT/KSA/DROP.
- ready  out  1  high in STREAM.
- err  out  1  one-cycle pulse when key_len is illegal at start.

Behaviour:
- Reset: state IDLE; i=j=0; out_valid=0; out_data=0; in_ready=0; busy=0; ready=0; err=0. Reset mid-operation aborts immediately.
- S-box: 256x8 register array with combinational reads. Every KSA/PRGA step completes in one cycle.
- IDLE: on start with 1<=key_len<=KEY_MAX_BYTES, latch key/key_len, clear counters, go to INIT. On illegal key_len, pulse err for one cycle and stay in IDLE.
- INIT: S[c]=c for c=0..255, one entry per cycle (256 cycles), then go to KSA with i=j=0, kidx=0.
- KSA: per cycle j'=j+S[i]+keybyte[kidx] mod 256, swap S[i],S[j'], i++.
  - kidx increments and wraps to 0 when it reaches key_len-1 (no modulo divider).
  - After i=255, clear i and j; go to DROP if DROP_N>0, else STREAM.
- PRGA step:
  - i'=i+1; j'=j+S[i']; t=S[i']+S[j'] using pre-swap values; swap S[i'],S[j'].
  - k = S_old[j'] if t==i'; S_old[i'] if t==j'; else S_old[t]. This is the post-swap lookup and covers the i'==j' case.
- DROP: one PRGA step per cycle for exactly DROP_N cycles, output discarded, then go to STREAM.
- STREAM:
  - ready=1; in_ready = !out_valid || out_ready.
  - On in_valid&&in_ready: one PRGA step; out_data<=in_data^k; out_valid<=1.
  - Else if out_ready: out_valid<=0.
  - PRGA advances only on an accepted input byte.
- Latency: ready rises 513+DROP_N cycles after the start cycle. Data latency is 1 cycle. Throughput is 1 byte/cycle with out_ready held high.
- Backpressure: while out_valid&&!out_ready, out_data is held stable and in_ready=0.
- start in STREAM: rekey. out_valid<=0 the next cycle and any pending byte is discarded; go to INIT (err if key_len is illegal, and stay in STREAM).
- start in INIT/KSA/DROP: ignored.
- Arithmetic: all index and j math is 8-bit wrap-around.

Decomposition:
- rc4_pkg holds:
  - state enum {IDLE, INIT, KSA, DROP, STREAM}, 3 bits;
  - SBOX_DEPTH=256 and BYTE_W=8;
  - a function computing KLW.
- Sub-module rc4_sbox holds:
  - the 256x8 array;
  - two combinational read ports (i', j'), with a third read port on the t index computed inside rc4_sbox from the two read values;
  - an init-write port;
  - a swap port (two addresses, writes both in one cycle; when the addresses are equal, a single write).
- FSM, counters, key mux and stream handshake live in rc4_stream.

Test Plan:
- Key "Key" (0x4B,0x65,0x79; key_len=3), DROP_N=0, feed "Plaintext" with out_ready=1 -> out_data BB F3 16 E8 D9 40 AF 0A D3; ready rises exactly 513 cycles after start.
- Same key, in_data=0x00 stream, out_ready low for 5 cycles after the first byte -> out_valid and out_data=EB held, in_ready=0. On release, the sequence continues 9F 77 81 with no bytes lost or duplicated.
- Mid-stream start with key "Wiki" (key_len=4, key=0x696B6957), feed "pedia" -> out_valid drops the next cycle, busy for 512 cycles, then out_data 10 21 BF 04 20.
- start with key_len=0, and again with key_len=KEY_MAX_BYTES+1 -> err is a one-cycle pulse each time, state stays IDLE, busy=0.
- DROP_N=3 instance, key "Key", in_data=0x00 stream -> first outputs 81 B7 34; ready rises at start+516.
- Assert rst midway through KSA -> next cycle all outputs at reset values. A fresh start with key "Secret" then yields keystream 04 D4 6B 05 3C A8 7B 59.

Source files
------------

// File: rtl/rc4_pkg.sv
// rc4_pkg: shared state encoding, sizes and helpers for the RC4 stream engine.
package rc4_pkg;

   localparam int SBOX_DEPTH = 256;
   localparam int BYTE_W     = 8;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      KSA,
      DROP,
      STREAM
   } rc4_state_t;

   // Width needed to hold a key length of 0..key_max_bytes.
   function automatic int klw_of(input int key_max_bytes);
      return $clog2(key_max_bytes + 1);
   endfunction

endpackage

// File: rtl/rc4_sbox.sv
// rc4_sbox: 256x8 RC4 permutation with two combinational read ports, a
// post-swap keystream lookup, an identity init-write port and a one-cycle swap.
module rc4_sbox
   import rc4_pkg::*;
(
   input  logic              clk,
   input  logic [BYTE_W-1:0] addr_a,
   input  logic [BYTE_W-1:0] addr_b,
   output logic [BYTE_W-1:0] rd_a,
   output logic [BYTE_W-1:0] rd_k,
   input  logic              init_en,
   input  logic [BYTE_W-1:0] init_addr,
   input  logic              swap_en
);

   logic [BYTE_W-1:0] s [SBOX_DEPTH];
   logic [BYTE_W-1:0] rd_b;
   logic [BYTE_W-1:0] t;

   // Reads at i'/j', then the keystream byte S[t] as it will look after the swap.
   always_comb begin
      // NOTE: every output of this block is assigned on every path, so no latch is inferred.
      rd_a = s[addr_a];
      rd_b = s[addr_b];
      t    = rd_a + rd_b;
      if (t == addr_a) begin
         rd_k = rd_b;
      end else if (t == addr_b) begin
         rd_k = rd_a;
      end else begin
         rd_k = s[t];
      end
   end

   // Init writes S[c]=c; swap exchanges S[a] and S[b] (single write when a==b).
   // NOTE: the array is deliberately left out of reset; INIT rewrites every entry before use.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so both swap writes use the pre-edge read values.
      if (init_en) begin
         s[init_addr] <= init_addr;
      end else if (swap_en) begin
         if (addr_a == addr_b) begin
            s[addr_a] <= rd_a;
         end else begin
            s[addr_a] <= rd_b;
            s[addr_b] <= rd_a;
         end
      end
   end

endmodule

// File: rtl/rc4_stream.sv
// rc4_stream: RC4 engine with configurable key length, drop-N discard,
// rekey-on-the-fly and a valid/ready byte stream on both sides.
module rc4_stream
   import rc4_pkg::*;
#(
   parameter int KEY_MAX_BYTES = 16,
   parameter int DROP_N        = 0,
   parameter int KLW           = klw_of(KEY_MAX_BYTES)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [8*KEY_MAX_BYTES-1:0] key,
   input  logic [KLW-1:0]             key_len,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [BYTE_W-1:0]          in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [BYTE_W-1:0]          out_data,
   output logic                       busy,
   output logic                       ready,
   output logic                       err
);

   rc4_state_t                 state, state_n;
   logic [BYTE_W-1:0]          i, j, j_next, addr_a, key_byte, rd_a, rd_k;
   logic [KLW-1:0]             kidx, key_len_r;
   logic [8*KEY_MAX_BYTES-1:0] key_r;
   logic [31:0]                drop_cnt;
   logic                       key_ok, rekey, bad_key, accept, init_en, swap_en;

   assign key_ok   = (key_len != '0) && (32'(key_len) <= 32'(KEY_MAX_BYTES));
   assign key_byte = BYTE_W'(key_r >> {kidx, 3'b000});

   // KSA reads S[i] and mixes in the key byte; PRGA reads S[i+1].
   assign addr_a = (state == KSA) ? i : i + 8'd1;
   assign j_next = j + rd_a + ((state == KSA) ? key_byte : 8'd0);

   assign ready    = (state == STREAM);
   assign busy     = (state == INIT) || (state == KSA) || (state == DROP);
   assign in_ready = (state == STREAM) && (!out_valid || out_ready);

   rc4_sbox u_sbox (
      .clk       (clk),
      .addr_a    (addr_a),
      .addr_b    (j_next),
      .rd_a      (rd_a),
      .rd_k      (rd_k),
      .init_en   (init_en),
      .init_addr (i),
      .swap_en   (swap_en)
   );

   // Next-state decode and per-cycle S-box controls.
   always_comb begin
      state_n = state;
      rekey   = 1'b0;
      bad_key = 1'b0;
      accept  = 1'b0;
      init_en = 1'b0;
      swap_en = 1'b0;
      case (state)
         IDLE, STREAM: begin
            if (start) begin
               rekey   = key_ok;
               bad_key = !key_ok;
               if (key_ok) state_n = INIT;
            end
            if ((state == STREAM) && !rekey && in_valid && in_ready) begin
               accept  = 1'b1;
               swap_en = 1'b1;
            end
         end
         INIT: begin
            init_en = 1'b1;
            if (i == 8'hFF) state_n = KSA;
         end
         KSA: begin
            swap_en = 1'b1;
            if (i == 8'hFF) state_n = (DROP_N > 0) ? DROP : STREAM;
         end
         DROP: begin
            swap_en = 1'b1;
            if (drop_cnt == 32'(DROP_N - 1)) state_n = STREAM;
         end
         default: state_n = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Index counters, latched key, error pulse and the output byte register.
   always_ff @(posedge clk) begin
      if (rst) begin
         i         <= '0;
         j         <= '0;
         kidx      <= '0;
         drop_cnt  <= '0;
         key_r     <= '0;
         key_len_r <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         err       <= 1'b0;
      end else begin
         err <= bad_key;
         if (rekey) begin
            key_r     <= key;
            key_len_r <= key_len;
            i         <= '0;
            j         <= '0;
            kidx      <= '0;
            drop_cnt  <= '0;
            out_valid <= 1'b0;
         end else begin
            case (state)
               INIT: i <= i + 8'd1;
               KSA: begin
                  i    <= i + 8'd1;
                  j    <= (i == 8'hFF) ? '0 : j_next;
                  kidx <= (kidx == key_len_r - KLW'(1)) ? '0 : kidx + KLW'(1);
               end
               DROP: begin
                  i        <= addr_a;
                  j        <= j_next;
                  drop_cnt <= drop_cnt + 32'd1;
               end
               STREAM: begin
                  if (accept) begin
                     i         <= addr_a;
                     j         <= j_next;
                     out_data  <= in_data ^ rd_k;
                     out_valid <= 1'b1;
                  end else if (out_ready) begin
                     out_valid <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
